// File: rtl/mmio_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mmio_ctrl_pkg
// Shared constants and types for the parametrised MMIO slot controller:
//   - register offsets inside the internal error/status slot
//   - default unpopulated-slot read data and default populated-slot mask
//   - capture record for the first bus error after a clear
//   - saturating increment helper for the error counter
// -----------------------------------------------------------------------------
package mmio_ctrl_pkg;

    // Register offsets inside the status slot
    localparam int unsigned STAT_CNT  = 0;
    localparam int unsigned STAT_INFO = 1;
    localparam int unsigned STAT_CTRL = 2;
    localparam int unsigned STAT_CLR  = 3;

    // Defaults for the controller parameters
    localparam logic [31:0] DEF_ERR_DATA  = 32'hFFFF_FFFF;
    localparam logic [63:0] DEF_SLOT_MASK = 64'h0000_0000_0000_030F;

    localparam int ERR_CNT_W  = 16;
    localparam int ERR_ADDR_W = 11;

    // Capture of the first error since the last clear
    typedef struct packed {
        logic                  sticky;
        logic                  proto;
        logic                  wr;
        logic [ERR_ADDR_W-1:0] addr;
    } err_cap_t;

    // Counter increment that holds at all-ones instead of wrapping
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (v == {ERR_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_ctrl_ext_err_status.sv
// -----------------------------------------------------------------------------
// mmio_err_status
// Internal error/status slot of the MMIO controller. Counts bus errors
// (saturating), captures the first error after a clear, holds the interrupt
// enable and drives a registered level interrupt.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   acc_wr_i          legal write to the status slot this cycle
//   reg_i             register offset of the current access
//   ctrl_bit_i        write data bit 0 (interrupt enable value)
//   err_evt_i         bus error event this cycle
//   err_addr_i        zero-extended slot/register address of the access
//   err_wr_i          write strobe of the access
//   err_proto_i       access had both read and write asserted
//   rd_data_o         read data for the addressed status register
//   err_irq_o         registered irq_en & sticky
// -----------------------------------------------------------------------------
module mmio_err_status
    import mmio_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  acc_wr_i,
    input  logic [REG_AW-1:0]     reg_i,
    input  logic                  ctrl_bit_i,
    input  logic                  err_evt_i,
    input  logic [ERR_ADDR_W-1:0] err_addr_i,
    input  logic                  err_wr_i,
    input  logic                  err_proto_i,
    output logic [31:0]           rd_data_o,
    output logic                  err_irq_o
);

    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    err_cap_t             cap_q, cap_d;
    logic                 irq_en_q, irq_en_d;
    logic                 err_irq_q;
    logic                 clr_s;
    logic                 ctrl_wr_s;

    assign clr_s     = acc_wr_i & (reg_i == REG_AW'(STAT_CLR));
    assign ctrl_wr_s = acc_wr_i & (reg_i == REG_AW'(STAT_CTRL));

    // Next-state for counter, capture record and interrupt enable
    always_comb begin
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        irq_en_d = irq_en_q;
        // A clear is a legal access, so it can never coincide with an error
        if (clr_s) begin
            cnt_d = '0;
            cap_d = '0;
        end else if (err_evt_i) begin
            cnt_d = sat_inc(cnt_q);
            // Only the first error after a clear is recorded
            if (!cap_q.sticky) begin
                cap_d.sticky = 1'b1;
                cap_d.proto  = err_proto_i;
                cap_d.wr     = err_wr_i;
                cap_d.addr   = err_addr_i;
            end else begin
                cap_d = cap_q;
            end
        end else begin
            cnt_d = cnt_q;
            cap_d = cap_q;
        end
        if (ctrl_wr_s) begin
            irq_en_d = ctrl_bit_i;
        end else begin
            irq_en_d = irq_en_q;
        end
    end

    // Status register state and the delayed interrupt level
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            cap_q     <= '0;
            irq_en_q  <= 1'b0;
            err_irq_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            irq_en_q  <= irq_en_d;
            err_irq_q <= irq_en_q & cap_q.sticky;
        end
    end

    // Status register read mux
    always_comb begin
        rd_data_o = 32'h0000_0000;
        case (reg_i)
            REG_AW'(STAT_CNT):  rd_data_o = {16'h0000, cnt_q};
            REG_AW'(STAT_INFO): rd_data_o = {cap_q.sticky, cap_q.proto, cap_q.wr,
                                             18'h0_0000, cap_q.addr};
            REG_AW'(STAT_CTRL): rd_data_o = {31'h0000_0000, irq_en_q};
            default:            rd_data_o = 32'h0000_0000;
        endcase
    end

    assign err_irq_o = err_irq_q;

endmodule

// File: rtl/mmio_ctrl_ext.sv
// -----------------------------------------------------------------------------
// mmio_ctrl_ext
// Parametrised MMIO slot controller between the FPro bus and the I/O slots.
// Decodes the slot and register address, fans out per-slot strobes to
// populated slots only, broadcasts register address and write data, returns
// read data (optionally registered with a valid strobe) and hosts an internal
// error/status slot at STAT_SLOT.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   mmio_cs/rd/wr            bus select and strobes
//   mmio_addr, mmio_wr_data  word address and write data
//   mmio_rd_data/_valid      read return
//   slot_*_array             per-slot strobes, broadcast address/data, read data
//   err_irq                  bus-error interrupt (level)
// -----------------------------------------------------------------------------
module mmio_ctrl_ext
    import mmio_ctrl_pkg::*;
#(
    parameter int          N_SLOT    = 64,
    parameter int          REG_AW    = 5,
    parameter logic [63:0] SLOT_MASK = DEF_SLOT_MASK,
    parameter int          STAT_SLOT = N_SLOT - 1,
    parameter bit          RD_PIPE   = 1'b1,
    parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mmio_cs,
    input  logic                           mmio_wr,
    input  logic                           mmio_rd,
    input  logic [20:0]                    mmio_addr,
    input  logic [31:0]                    mmio_wr_data,
    output logic [31:0]                    mmio_rd_data,
    output logic                           mmio_rd_valid,
    output logic [N_SLOT-1:0]              slot_cs_array,
    output logic [N_SLOT-1:0]              slot_mem_rd_array,
    output logic [N_SLOT-1:0]              slot_mem_wr_array,
    output logic [N_SLOT-1:0][REG_AW-1:0]  slot_reg_addr_array,
    input  logic [N_SLOT-1:0][31:0]        slot_rd_data_array,
    output logic [N_SLOT-1:0][31:0]        slot_wr_data_array,
    output logic                           err_irq
);

    localparam int SW = $clog2(N_SLOT);
    localparam int AW = REG_AW + SW;

    logic [SW-1:0]         slot_s;
    logic [REG_AW-1:0]     reg_s;
    logic                  is_stat_s;
    logic                  populated_s;
    logic                  proto_s;
    logic                  ext_sel_s;
    logic                  err_evt_s;
    logic                  rd_req_s;
    logic [31:0]           stat_rd_s;
    logic [31:0]           rd_mux_s;
    logic [ERR_ADDR_W-1:0] err_addr_s;
    logic                  unused_addr_s;

    assign slot_s      = mmio_addr[AW-1:REG_AW];
    assign reg_s       = mmio_addr[REG_AW-1:0];
    assign is_stat_s   = (slot_s == SW'(STAT_SLOT));
    assign populated_s = SLOT_MASK[slot_s] | is_stat_s;
    assign proto_s     = mmio_rd & mmio_wr;
    // The status slot is internal, so it never gets an external strobe even
    // if its bit happens to be set in the mask
    assign ext_sel_s   = mmio_cs & SLOT_MASK[slot_s] & ~is_stat_s & ~proto_s;
    assign err_evt_s   = mmio_cs & (mmio_rd | mmio_wr) & (~populated_s | proto_s);
    assign rd_req_s    = mmio_cs & mmio_rd;
    assign err_addr_s  = ERR_ADDR_W'(mmio_addr[AW-1:0]);
    assign unused_addr_s = ^mmio_addr[20:AW];

    // Per-slot strobe fan-out to the addressed populated slot
    always_comb begin
        slot_cs_array     = '0;
        slot_mem_rd_array = '0;
        slot_mem_wr_array = '0;
        if (ext_sel_s) begin
            slot_cs_array[slot_s]     = 1'b1;
            slot_mem_rd_array[slot_s] = mmio_rd;
            slot_mem_wr_array[slot_s] = mmio_wr;
        end else begin
            slot_cs_array     = '0;
            slot_mem_rd_array = '0;
            slot_mem_wr_array = '0;
        end
    end

    // Broadcast register address and write data to every slot
    always_comb begin
        slot_reg_addr_array = '0;
        slot_wr_data_array  = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            slot_reg_addr_array[i] = reg_s;
            slot_wr_data_array[i]  = mmio_wr_data;
        end
    end

    mmio_err_status #(
        .REG_AW (REG_AW)
    ) u_err_status (
        .clk         (clk),
        .reset       (reset),
        .acc_wr_i    (mmio_cs & is_stat_s & mmio_wr & ~proto_s),
        .reg_i       (reg_s),
        .ctrl_bit_i  (mmio_wr_data[0]),
        .err_evt_i   (err_evt_s),
        .err_addr_i  (err_addr_s),
        .err_wr_i    (mmio_wr),
        .err_proto_i (proto_s),
        .rd_data_o   (stat_rd_s),
        .err_irq_o   (err_irq)
    );

    // Read-return mux: error data, status slot, or the addressed slot
    always_comb begin
        rd_mux_s = ERR_DATA;
        if (proto_s || !populated_s) begin
            rd_mux_s = ERR_DATA;
        end else if (is_stat_s) begin
            rd_mux_s = stat_rd_s;
        end else begin
            rd_mux_s = slot_rd_data_array[slot_s];
        end
    end

    generate
        if (RD_PIPE) begin : g_rd_pipe
            logic [31:0] rd_data_q;
            logic        rd_valid_q;

            // Registered read return; data holds until the next read
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q  <= 32'h0000_0000;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_req_s;
                    if (rd_req_s) begin
                        rd_data_q <= rd_mux_s;
                    end else begin
                        rd_data_q <= rd_data_q;
                    end
                end
            end

            assign mmio_rd_data  = rd_data_q;
            assign mmio_rd_valid = rd_valid_q;
        end else begin : g_rd_comb
            assign mmio_rd_data  = rd_mux_s;
            assign mmio_rd_valid = rd_req_s;
        end
    endgenerate

endmodule

// File: tb/tb_mmio_ctrl_ext.sv
module tb_mmio_ctrl_ext;

    localparam int          N_SLOT = 64;
    localparam int          REG_AW = 5;
    localparam int          STAT   = N_SLOT - 1;
    localparam logic [63:0] MASK   = 64'h0000_0000_0000_030F;
    localparam logic [31:0] ERRD   = 32'hFFFF_FFFF;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          mmio_cs, mmio_wr, mmio_rd;
    logic [20:0]                   mmio_addr;
    logic [31:0]                   mmio_wr_data;
    logic [31:0]                   mmio_rd_data;
    logic                          mmio_rd_valid;
    logic [N_SLOT-1:0]             slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
    logic [N_SLOT-1:0][REG_AW-1:0] slot_reg_addr_array;
    logic [N_SLOT-1:0][31:0]       slot_rd_data_array;
    logic [N_SLOT-1:0][31:0]       slot_wr_data_array;
    logic                          err_irq;

    always #5 clk = ~clk;

    mmio_ctrl_ext dut (
        .clk                 (clk),
        .reset               (reset),
        .mmio_cs             (mmio_cs),
        .mmio_wr             (mmio_wr),
        .mmio_rd             (mmio_rd),
        .mmio_addr           (mmio_addr),
        .mmio_wr_data        (mmio_wr_data),
        .mmio_rd_data        (mmio_rd_data),
        .mmio_rd_valid       (mmio_rd_valid),
        .slot_cs_array       (slot_cs_array),
        .slot_mem_rd_array   (slot_mem_rd_array),
        .slot_mem_wr_array   (slot_mem_wr_array),
        .slot_reg_addr_array (slot_reg_addr_array),
        .slot_rd_data_array  (slot_rd_data_array),
        .slot_wr_data_array  (slot_wr_data_array),
        .err_irq             (err_irq)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    rd_exp_t     mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] sdata [N_SLOT];

    // Reference model of the status slot
    int unsigned m_cnt;
    bit          m_sticky, m_proto, m_wr, m_irq_en, m_irq;
    logic [10:0] m_addr;

    always_comb begin
        for (int i = 0; i < N_SLOT; i++) slot_rd_data_array[i] = sdata[i];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_stat(input int r);
        case (r)
            0:       return {16'h0000, m_cnt[15:0]};
            1:       return {m_sticky, m_proto, m_wr, 18'h0, m_addr};
            2:       return {31'h0, m_irq_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_sticky = 0; m_proto = 0; m_wr = 0; m_addr = 11'h0;
    endtask

    // One bus cycle: drive, check combinational strobes, predict, clock, update model
    task automatic cycle(input bit rst, input bit cs, input bit rd, input bit wr,
                         input int slot, input int r, input logic [31:0] wd);
        bit          proto, pop, sel, evt;
        logic [63:0] e_cs, e_rd, e_wr;
        rd_exp_t     e;
        reset = rst; mmio_cs = cs; mmio_rd = rd; mmio_wr = wr;
        mmio_addr = 21'((slot << REG_AW) | r); mmio_wr_data = wd;
        #1;
        proto = rd && wr;
        pop   = MASK[slot] || (slot == STAT);
        sel   = cs && MASK[slot] && (slot != STAT) && !proto;
        e_cs  = sel ? (64'd1 << slot) : 64'd0;
        e_rd  = (sel && rd) ? (64'd1 << slot) : 64'd0;
        e_wr  = (sel && wr) ? (64'd1 << slot) : 64'd0;
        chk("slot_cs", slot_cs_array, e_cs);
        chk("slot_rd", slot_mem_rd_array, e_rd);
        chk("slot_wr", slot_mem_wr_array, e_wr);
        chk("bcast_addr", 64'(slot_reg_addr_array[slot]), 64'(r));
        chk("bcast_data", 64'(slot_wr_data_array[slot]), 64'(wd));
        if (!rst && cs && rd) begin
            e.data = (proto || !pop) ? ERRD : ((slot == STAT) ? model_stat(r) : sdata[slot]);
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        evt = cs && (rd || wr) && (!pop || proto);
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_clear(); m_irq_en = 0; m_irq = 0;
            exp_q.delete();
        end else begin
            m_irq = m_irq_en && m_sticky;
            if (cs && wr && !proto && slot == STAT) begin
                if (r == 2) m_irq_en = wd[0];
                if (r == 3) model_clear();
            end
            if (evt) begin
                if (m_cnt < 65535) m_cnt++;
                if (!m_sticky) begin
                    m_sticky = 1; m_proto = proto; m_wr = wr;
                    m_addr = 11'((slot << REG_AW) | r);
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents read data
    always @(negedge clk) begin
        if (mon_en) begin
            if (mmio_rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rd_valid: unexpected valid, data %h (cycle %0d)", mmio_rd_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rd_data", 64'(mmio_rd_data), 64'(mon_e.data));
                    chk("rd_latency", 64'(cyc), 64'(mon_e.due));
                end
            end
            chk("err_irq", 64'(err_irq), 64'(m_irq));
        end
    end

    initial begin
        int s, r;
        bit c, rd, wr;
        for (int i = 0; i < N_SLOT; i++) sdata[i] = $urandom;
        sdata[3] = 32'h0000_00A5;
        model_clear(); m_irq_en = 0; m_irq = 0;
        reset = 1'b1; mmio_cs = 0; mmio_rd = 0; mmio_wr = 0;
        mmio_addr = 21'h0; mmio_wr_data = 32'h0;
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        mon_en = 1'b1;
        chk("reset_rd_data", 64'(mmio_rd_data), 64'h0);
        chk("reset_rd_valid", 64'(mmio_rd_valid), 64'h0);
        chk("reset_irq", 64'(err_irq), 64'h0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, STAT, i, 32'h0);

        // Legal write to populated slot 2, then confirm no error counted
        cycle(0, 1, 0, 1, 2, 0, 32'h55);
        idle();
        cycle(0, 1, 1, 0, STAT, 0, 32'h0);

        // Single and back-to-back reads
        cycle(0, 1, 1, 0, 3, 0, 32'h0);
        idle();
        cycle(0, 1, 1, 0, 0, 0, 32'h0);
        cycle(0, 1, 1, 0, 3, 0, 32'h0);
        idle();

        // Unpopulated read then write; capture holds the first
        cycle(0, 1, 1, 0, 5, 7, 32'h0);
        cycle(0, 1, 1, 0, STAT, 1, 32'h0);
        cycle(0, 1, 0, 1, 6, 2, 32'h1234);
        cycle(0, 1, 1, 0, STAT, 0, 32'h0);
        cycle(0, 1, 1, 0, STAT, 1, 32'h0);

        // cs low with strobes: no event, no valid
        cycle(0, 0, 1, 1, 5, 1, 32'h0);
        cycle(0, 0, 1, 0, 3, 0, 32'h0);

        // Protocol error with interrupt enabled, then clear
        cycle(0, 1, 0, 1, STAT, 3, 32'h0);
        cycle(0, 1, 0, 1, STAT, 2, 32'h1);
        cycle(0, 1, 1, 1, 0, 4, 32'h0);
        idle(); idle();
        cycle(0, 1, 1, 0, STAT, 1, 32'h0);
        cycle(0, 1, 0, 1, STAT, 3, 32'h0);
        idle(); idle();
        cycle(0, 1, 1, 0, STAT, 0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            s  = ($urandom_range(0, 3) == 0) ? STAT : $urandom_range(0, N_SLOT - 1);
            r  = (s == STAT) ? $urandom_range(0, 5) : $urandom_range(0, 31);
            c  = ($urandom_range(0, 7) != 0);
            rd = $urandom_range(0, 1);
            wr = ($urandom_range(0, 3) == 0) ? 1'b1 : !rd;
            if (s == STAT && r == 3 && $urandom_range(0, 3) != 0) r = 0;
            cycle(0, c, rd, wr, s, r, $urandom);
        end

        // Counter saturation
        cycle(0, 1, 0, 1, STAT, 3, 32'h0);
        for (int i = 0; i < 65534; i++) cycle(0, 1, 0, 1, 5, 1, 32'h0);
        cycle(0, 1, 1, 0, STAT, 0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 6, 0, 32'h0);
        cycle(0, 1, 1, 0, STAT, 0, 32'h0);
        idle();

        // Reset arriving with a read drops the pending valid
        cycle(0, 1, 1, 0, 3, 0, 32'h0);
        cycle(1, 1, 1, 0, 3, 0, 32'h0);
        chk("rst_drop_valid", 64'(mmio_rd_valid), 64'h0);
        chk("rst_drop_data", 64'(mmio_rd_data), 64'h0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, STAT, i, 32'h0);
        idle(); idle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl_ext.md
# mmio_ctrl_ext

Parametrised MMIO slot controller that sits between the FPro bus and the I/O slot cores, replacing the fixed 64-slot controller in the MMIO subsystem.
- Adds a configurable slot count and a populated-slot mask.
- Adds an optionally registered read-return path with a valid strobe.
- Adds an internal bus-error status slot that counts and captures accesses to unpopulated slots and protocol violations, and raises an interrupt on them.

## Interface
- N_SLOT, 64: number of slots; power of 2, 2..64; SW = clog2(N_SLOT).
- REG_AW, 5: register address bits per slot.
- SLOT_MASK, 64'h0000_0000_0000_030F: bit i = 1 means slot i is populated. The status slot is implicitly populated.
- STAT_SLOT, N_SLOT-1: slot index of the internal error/status slot.
- RD_PIPE, 1: 1 = registered read return; 0 = combinational.
- ERR_DATA, 32'hFFFF_FFFF: read data returned for unpopulated slots.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- mmio_cs  in  1  bus select.
- mmio_wr  in  1  write strobe.
- mmio_rd  in  1  read strobe.
- mmio_addr  in  21  word address; bits [REG_AW+SW-1:0] used.
- mmio_wr_data  in  32  write data.
- mmio_rd_data  out  32  read data.
- mmio_rd_valid  out  1  read data valid.
- slot_cs_array  out  N_SLOT  per-slot select.
- slot_mem_rd_array  out  N_SLOT  per-slot read strobe.
- slot_mem_wr_array  out  N_SLOT  per-slot write strobe.
- slot_reg_addr_array  out  [N_SLOT][REG_AW]  register address, broadcast to all slots.
- slot_rd_data_array  in  [N_SLOT][32]  slot read data.
- slot_wr_data_array  out  [N_SLOT][32]  write data, broadcast to all slots.
- err_irq  out  1  level interrupt = irq_en & err_sticky.

## Operation
- **Decode:**
  - slot = mmio_addr[REG_AW+SW-1:REG_AW]; reg = mmio_addr[REG_AW-1:0].
  - Strobes are combinational from the bus: slot_cs[slot] = mmio_cs; slot_mem_rd[slot] = mmio_cs & mmio_rd; likewise for wr.
- **Strobe suppression:** no external strobe is issued for any of:
  - an unpopulated slot;
  - STAT_SLOT;
  - mmio_cs = 0;
  - a protocol error (mmio_rd & mmio_wr both high).
- **Read mux:**
  - Populated slot returns slot_rd_data_array[slot].
  - STAT_SLOT returns its internal register.
  - Unpopulated slot or protocol error returns ERR_DATA.
- **Error event:** an access (cs & (rd|wr)) to an unpopulated slot, or a protocol error. On each event:
  - err_cnt (16 b) increments and saturates at 16'hFFFF.
  - If err_sticky = 0: capture err_addr <= mmio_addr[REG_AW+SW-1:0], err_wr <= mmio_wr, err_proto <= (rd&wr), and set err_sticky. Later errors do not overwrite the capture.
- **Status slot registers** (reg offset):
  - 0 R: {16'b0, err_cnt}.
  - 1 R: {err_sticky, err_proto, err_wr, 18'b0, err_addr[10:0]}; err_addr is zero-extended to 11 b.
  - 2 RW: bit0 irq_en.
  - 3 W: any write clears err_cnt, err_sticky, err_addr, err_wr and err_proto.
  - Other offsets read 0; writes to them are ignored.
- **Boundary conditions:**
  - A write to offset 3 is a legal access, so clear and error never coincide.
  - mmio_cs = 0 with rd/wr high: no event, no valid.
  - Reset mid-read (RD_PIPE=1): the pending valid is dropped.

## Timing
- Slot strobes and broadcast address/data: same cycle as the bus request, combinational.
- RD_PIPE=1: mmio_rd_data and mmio_rd_valid are registered and valid the cycle after mmio_cs & mmio_rd; held until the next read. Back-to-back reads give valid on consecutive cycles.
- RD_PIPE=0: mmio_rd_data is combinational; mmio_rd_valid = mmio_cs & mmio_rd in the same cycle.
- Error counter, capture and irq_en update on the clock edge ending the access. err_irq is registered and follows one cycle after the event or write.
- **Reset values:**
  - mmio_rd_data, mmio_rd_valid = 0.
  - err_cnt, err_addr, err_wr, err_proto, err_sticky, irq_en = 0; err_irq = 0.
  - All strobes follow their inputs and are 0 when mmio_cs = 0.

## Structure
- Package mmio_ctrl_pkg holds:
  - STAT register offset constants: STAT_CNT=0, STAT_INFO=1, STAT_CTRL=2, STAT_CLR=3.
  - Default ERR_DATA and the default SLOT_MASK.
  - A typedef for the capture record {sticky, proto, wr, addr}.
- Sub-module mmio_err_status contains the status slot:
  - counter, capture, control and irq registers;
  - its own 32-bit read mux.
- The top level contains the decode, the strobe fan-out and the read-return pipeline.

## Test plan
- Reset, then write 32'h55 to slot 2 reg 0 -> slot_mem_wr_array[2]=1 and slot_reg_addr_array[2]=0 for exactly one cycle; no error; err_cnt=0.
- Slot 3 drives 32'h0000_00A5; read slot 3 reg 0 with RD_PIPE=1 -> mmio_rd_data=32'hA5 with mmio_rd_valid=1 on the next cycle. Back-to-back reads of slots 0 and 3 -> valid on two consecutive cycles, data in order.
- Read slot 5 reg 7, then write slot 6 -> data 32'hFFFF_FFFF and no strobes. After the read, STAT reg1 = sticky=1, wr=0, addr=(5<<5)|7. After the write, err_cnt=2 and the capture is unchanged.
- Write irq_en=1, assert mmio_rd & mmio_wr to slot 0 -> no slot strobe, err_proto=1, err_irq=1 one cycle later. Write STAT reg3 -> err_cnt=0 and err_irq=0.
- Force err_cnt to 16'hFFFE, then issue 3 unpopulated accesses -> err_cnt saturates at 16'hFFFF. Assert reset during a RD_PIPE=1 read -> mmio_rd_valid=0 and all status registers=0.
